// File: rtl/sram_ctrl_pkg.sv
// Shared constants and request bundle for the SRAM port-0 initiator.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_W  = 10;
    localparam int SRAM_DATA_W  = 8;
    localparam int SRAM_WMASK_W = 1;

    // Accept edge to FIFO write edge
    localparam int RD_LAT = 2;

    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_IDLE = 1'b1;

    typedef struct packed {
        logic                    we;
        logic [SRAM_ADDR_W-1:0]  addr;
        logic [SRAM_DATA_W-1:0]  wdata;
        logic [SRAM_WMASK_W-1:0] wmask;
    } sram_req_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous response FIFO; pointers wrap modulo DEPTH (power of 2).
module rsp_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/sram_port0_ctrl.sv
// Port-0 (1RW) initiator for the sky130 1 KiB SRAM: registered pins,
// credit-guarded in-order read responses.
module sram_port0_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int WMASK_W   = SRAM_WMASK_W,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    input  logic [WMASK_W-1:0] req_wmask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               sram_csb0,
    output logic               sram_web0,
    output logic [WMASK_W-1:0] sram_wmask0,
    output logic [ADDR_W-1:0]  sram_addr0,
    output logic [DATA_W-1:0]  sram_din0,
    input  logic [DATA_W-1:0]  sram_dout0
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    sram_req_t         w_req;
    logic              w_acc;
    logic              w_rd_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  r_credits;
    logic [RD_LAT-1:0] r_rd_pipe;

    assign w_req = '{we:    req_we,
                     addr:  req_addr,
                     wdata: req_wdata,
                     wmask: req_wmask};

    // Writes bypass the credit check; rsp_ready never reaches req_ready
    assign req_ready = !rst && (req_we || r_credits != '0);
    assign w_acc     = req_valid && req_ready;
    assign w_rd_acc  = w_acc && !req_we;
    assign w_push    = r_rd_pipe[RD_LAT-1];
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_valid = !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_csb0   <= CSB_IDLE;
            sram_web0   <= WEB_IDLE;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else if (w_acc) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= !w_req.we;
            sram_wmask0 <= w_req.we ? w_req.wmask : '0;
            sram_addr0  <= w_req.addr;
            sram_din0   <= w_req.we ? w_req.wdata : sram_din0;
        end else begin
            sram_csb0   <= CSB_IDLE;
            sram_web0   <= WEB_IDLE;
            sram_wmask0 <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[RD_LAT-2:0], w_rd_acc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CNT_W'(RSP_DEPTH);
        end else begin
            unique case ({w_rd_acc, w_pop})
                2'b10:   r_credits <= r_credits - CNT_W'(1);
                2'b01:   r_credits <= r_credits + CNT_W'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (sram_dout0),
        .i_pop   (w_pop),
        .o_rdata (rsp_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full));

    a_credit_sum: assert property (@(posedge clk) disable iff (rst)
        int'(r_credits) + int'(w_count) + $countones(r_rd_pipe) == RSP_DEPTH);

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Scoreboard bench for sram_port0_ctrl with a behavioural port-0 SRAM model.
module tb_sram_port0_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic [0:0] req_wmask;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       sram_csb0;
    logic       sram_web0;
    logic [0:0] sram_wmask0;
    logic [9:0] sram_addr0;
    logic [7:0] sram_din0;
    logic [7:0] sram_dout0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    bit   [7:0] mem    [1024];
    bit   [7:0] shadow [1024];
    logic [7:0] exp_q  [$];
    int         pop_cyc_q [$];

    sram_port0_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Macro latches pins at the edge; read data valid for the next edge
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                if (sram_wmask0[0]) mem[sram_addr0] <= sram_din0;
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [9:0] a,
                         input logic [7:0] d, input int bound,
                         output bit ok);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                if (we) shadow[a] = d;
                else exp_q.push_back(shadow[a]);
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit         held = 1'b0;
    logic [7:0] held_d;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            held = 1'b0;
        end else if (rsp_valid) begin
            if (rsp_ready) begin
                pop_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got 0x%0h expected none",
                             rsp_rdata);
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
                end
                held = 1'b0;
            end else begin
                if (held) chk("rsp_hold", rsp_rdata, held_d);
                held   = 1'b1;
                held_d = rsp_rdata;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    bit ok;
    int t0;

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_addr = '0;
        req_wdata = '0;
        req_wmask = '0;
        idle();

        // reset
        wait_cyc(3);
        chk("rst_ready_low", req_ready, 0);
        chk("rst_csb", sram_csb0, 1);
        rst = 1'b0;
        #1;
        chk("rst_web", sram_web0, 1);
        chk("rst_wmask", sram_wmask0, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 1);

        // back-to-back writes
        issue(1'b1, 10'h00A, 8'h55, 4, ok);
        chk("w1_ok", ok, 1);
        chk("w1_pins", {sram_csb0, sram_web0, sram_wmask0,
                        sram_addr0, sram_din0},
            {1'b0, 1'b0, 1'b1, 10'h00A, 8'h55});
        issue(1'b1, 10'h00B, 8'h44, 4, ok);
        chk("w2_pins", {sram_csb0, sram_web0, sram_wmask0,
                        sram_addr0, sram_din0},
            {1'b0, 1'b0, 1'b1, 10'h00B, 8'h44});
        issue(1'b1, 10'h00C, 8'h33, 4, ok);
        chk("w3_pins", {sram_csb0, sram_web0, sram_wmask0,
                        sram_addr0, sram_din0},
            {1'b0, 1'b0, 1'b1, 10'h00C, 8'h33});
        idle();
        wait_cyc(1);
        chk("w_idle_pins", {sram_csb0, sram_web0, sram_wmask0,
                            sram_addr0, sram_din0},
            {1'b1, 1'b1, 1'b0, 10'h00C, 8'h33});

        // in-order reads at full rate
        pop_cyc_q.delete();
        issue(1'b0, 10'h00A, 8'h00, 4, ok);
        t0 = cyc;
        chk("r1_pins", {sram_csb0, sram_web0, sram_addr0},
            {1'b0, 1'b1, 10'h00A});
        issue(1'b0, 10'h00B, 8'h00, 4, ok);
        issue(1'b0, 10'h00C, 8'h00, 4, ok);
        idle();
        wait_cyc(6);
        chk("rd3_drained", exp_q.size(), 0);
        chk("rd3_count", pop_cyc_q.size(), 3);
        if (pop_cyc_q.size() == 3) begin
            chk("rd_latency", pop_cyc_q[0] - t0, 2);
            chk("rd_throughput", pop_cyc_q[2] - pop_cyc_q[0], 2);
        end

        // backpressure and credits
        rsp_ready = 1'b0;
        issue(1'b0, 10'h00A, 8'h00, 2, ok);
        chk("bp_r1_ok", ok, 1);
        issue(1'b0, 10'h00B, 8'h00, 2, ok);
        chk("bp_r2_ok", ok, 1);
        issue(1'b0, 10'h00C, 8'h00, 2, ok);
        chk("bp_r3_ok", ok, 1);
        issue(1'b0, 10'h00A, 8'h00, 2, ok);
        chk("bp_r4_ok", ok, 1);
        issue(1'b0, 10'h00B, 8'h00, 6, ok);
        chk("bp_r5_stalled", ok, 0);
        chk("bp_ready_low", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        issue(1'b1, 10'h100, 8'h77, 2, ok);
        chk("bp_write_ok", ok, 1);
        rsp_ready = 1'b1;
        issue(1'b0, 10'h00B, 8'h00, 20, ok);
        chk("bp_r5_ok", ok, 1);
        issue(1'b0, 10'h100, 8'h00, 20, ok);
        chk("bp_r6_ok", ok, 1);
        idle();
        wait_cyc(8);
        chk("bp_drained", exp_q.size(), 0);

        // read-after-write at top address, unwritten read
        pop_cyc_q.delete();
        issue(1'b1, 10'h3FF, 8'hA5, 4, ok);
        issue(1'b0, 10'h3FF, 8'h00, 4, ok);
        chk("raw_ok", ok, 1);
        issue(1'b0, 10'h000, 8'h00, 4, ok);
        idle();
        wait_cyc(6);
        chk("raw_drained", exp_q.size(), 0);
        chk("raw_count", pop_cyc_q.size(), 2);

        // reset with reads in flight
        issue(1'b0, 10'h00A, 8'h00, 4, ok);
        issue(1'b0, 10'h00B, 8'h00, 4, ok);
        idle();
        rst = 1'b1;
        exp_q.delete();
        wait_cyc(1);
        rst = 1'b0;
        #1;
        chk("mid_rst_credits", dut.r_credits, 4);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_csb", sram_csb0, 1);
        pop_cyc_q.delete();
        wait_cyc(6);
        chk("mid_rst_no_rsp", pop_cyc_q.size(), 0);
        issue(1'b0, 10'h00C, 8'h00, 4, ok);
        chk("post_rst_rd_ok", ok, 1);
        idle();
        wait_cyc(6);
        chk("post_rst_count", pop_cyc_q.size(), 1);
        chk("post_rst_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
